fetch_pc_unit: RTL

- Next-generation instruction-fetch front end for the MIPS core. Replaces the single-cycle next-PC mux chain (PC+4 / branch / jump / jr) with a registered PC and a parametrised direct-mapped branch target buffer (BTB) holding 2-bit saturating predictors.
- Branches, jumps and jr are resolved downstream and reported back. On a mispredict this block redirects the PC and flushes younger instructions.
- Sits between the instruction memory address port and the execute stage.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/btb_table.sv | 95 +++++++++
 rtl/fetch_pc_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch front end:
//   - cnt_e      : 2-bit saturating branch-predictor counter encodings
//   - btb_meta_t : control part of a BTB entry (valid bit + predictor counter).
//                  Tag and target are sized by the instantiating module and are
//                  held next to this struct in the table.
//   - clog2      : ceiling log2, used to size the BTB index.
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    typedef struct packed {
        logic valid;
        cnt_e cnt;
    } btb_meta_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/btb_table.sv
// -----------------------------------------------------------------------------
// btb_table
// Direct-mapped branch target buffer with 2-bit saturating predictors.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (clears valid, counters -> WNT)
//   rd_pc      in   lookup address (combinational read port)
//   rd_taken   out  entry hit and counter predicts taken
//   rd_target  out  stored target of the indexed entry
//   wr_en      in   one resolution to fold into the table at the clock edge
//   wr_pc      in   PC of the resolved instruction
//   wr_taken   in   actual outcome
//   wr_target  in   actual taken target
//
// A read of an index written in the same cycle returns the old contents.
// -----------------------------------------------------------------------------
module btb_table
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_pc,
    output logic              rd_taken,
    output logic [ADDR_W-1:0] rd_target,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_pc,
    input  logic              wr_taken,
    input  logic [ADDR_W-1:0] wr_target
);

    localparam int IDX_W = clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    btb_meta_t         meta    [BTB_DEPTH];
    logic [TAG_W-1:0]  tag_mem [BTB_DEPTH];
    logic [ADDR_W-1:0] tgt_mem [BTB_DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;

    // Instructions are word aligned; the byte-offset bits carry no information.
    logic unused_bits;
    assign unused_bits = ^{rd_pc[1:0], wr_pc[1:0]};

    function automatic cnt_e sat_update(input cnt_e c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : cnt_e'(c + 2'd1);
        end
        return (c == SNT) ? SNT : cnt_e'(c - 2'd1);
    endfunction

    assign rd_idx    = rd_pc[IDX_W+1:2];
    assign rd_tag    = rd_pc[ADDR_W-1:IDX_W+2];
    assign rd_hit    = meta[rd_idx].valid && (tag_mem[rd_idx] == rd_tag);
    assign rd_taken  = rd_hit && meta[rd_idx].cnt[1];
    assign rd_target = tgt_mem[rd_idx];

    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[ADDR_W-1:IDX_W+2];
    assign wr_hit = meta[wr_idx].valid && (tag_mem[wr_idx] == wr_tag);

    // Control state: valid bits and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                meta[i] <= '{valid: 1'b0, cnt: WNT};
            end
        end else if (wr_en) begin
            if (wr_hit) begin
                meta[wr_idx].cnt <= sat_update(meta[wr_idx].cnt, wr_taken);
            end else if (wr_taken) begin
                meta[wr_idx] <= '{valid: 1'b1, cnt: WT};
            end
        end
    end

    // Data state: tag and target. Any taken resolution either allocates the
    // entry or refreshes a hit (same tag), so both cases share one write. A
    // write racing a reset edge is harmless because the valid bit is cleared.
    always_ff @(posedge clk) begin
        if (wr_en && wr_taken) begin
            tag_mem[wr_idx] <= wr_tag;
            tgt_mem[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Instruction-fetch PC generator with BTB-based branch prediction and
// mispredict redirect.
//
// Ports:
//   clk_i              in   clock, rising edge
//   rst_i              in   asynchronous active-low reset
//   stall_i            in   hold the PC (overridden by a redirect)
//   pc_o               out  registered fetch address
//   pc_plus4_o         out  pc_o + 4
//   pred_taken_o       out  BTB predicts taken for pc_o
//   pred_target_o      out  predicted next fetch address
//   res_valid_i        in   a control transfer resolves this cycle
//   res_pc_i           in   PC of the resolved instruction
//   res_taken_i        in   actual outcome
//   res_target_i       in   actual taken target
//   res_pred_taken_i   in   prediction carried with the instruction
//   res_pred_target_i  in   predicted target carried with the instruction
//   flush_o            out  mispredict this cycle; younger instructions killed
//   mispred_cnt_o      out  saturating mispredict count
// -----------------------------------------------------------------------------
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                BTB_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              res_valid_i,
    input  logic [ADDR_W-1:0] res_pc_i,
    input  logic              res_taken_i,
    input  logic [ADDR_W-1:0] res_target_i,
    input  logic              res_pred_taken_i,
    input  logic [ADDR_W-1:0] res_pred_target_i,
    output logic              flush_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    logic [ADDR_W-1:0] pc_p0;
    logic [ADDR_W-1:0] pc_next;
    logic [CNT_W-1:0]  mispred_cnt_p0;
    logic              btb_taken;
    logic [ADDR_W-1:0] btb_target;
    logic [ADDR_W-1:0] actual_next;
    logic              mispredict;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    btb_table #(
        .ADDR_W    (ADDR_W),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .rd_pc     (pc_p0),
        .rd_taken  (btb_taken),
        .rd_target (btb_target),
        .wr_en     (res_valid_i),
        .wr_pc     (res_pc_i),
        .wr_taken  (res_taken_i),
        .wr_target (res_target_i)
    );

    assign pc_plus4_o    = pc_p0 + ADDR_W'(4);
    assign pred_taken_o  = btb_taken;
    assign pred_target_o = btb_taken ? btb_target : pc_plus4_o;

    assign actual_next = res_taken_i ? res_target_i : res_pc_i + ADDR_W'(4);
    assign mispredict  = res_valid_i &&
                         ((res_pred_taken_i != res_taken_i) ||
                          (res_taken_i && (res_pred_target_i != res_target_i)));

    // Gated so that a resolution arriving while in reset never reports a flush.
    assign flush_o = mispredict && rst_i;

    // A redirect outranks a stall: the flushed pipe has nothing to hold for.
    always_comb begin
        pc_next = pc_plus4_o;
        if (mispredict) begin
            pc_next = actual_next;
        end else if (stall_i) begin
            pc_next = pc_p0;
        end else if (pred_taken_o) begin
            pc_next = pred_target_o;
        end
    end

    // Stage 0: fetch PC and mispredict counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_p0          <= RESET_PC;
            mispred_cnt_p0 <= '0;
        end else begin
            pc_p0 <= pc_next;
            if (mispredict) begin
                mispred_cnt_p0 <= sat_inc(mispred_cnt_p0);
            end
        end
    end

    assign pc_o          = pc_p0;
    assign mispred_cnt_o = mispred_cnt_p0;

endmodule
